// File: rtl/sysarr_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : sysarr_operand_loader
// Purpose  : Feeds the 3x3 systolic matrix-multiply array. Packs a byte
//            stream (9 A elements, then 9 B elements, row-major) into 72-bit
//            operand words held in two ping-pong banks, and drives the
//            array's start / valid handshake from whichever bank is ready.
// Ports    : clk, rst_n              clock, async active-low reset
//            in_data/in_valid/in_last/in_ready   element stream (valid/ready)
//            A, B                    operand words, element (r,c) at
//                                    bits [ELEM_W*(3r+c) +: ELEM_W]
//            start / arr_valid       request to / result-valid from array
//            done                    1-cycle pulse, array result valid
//            busy                    bank full or issue in progress
//            err_len / err_tmo       1-cycle pulses: bad in_last / timeout
// Revision : 1.0 - initial release
// ============================================================================
module sysarr_operand_loader #(
  parameter int ELEM_W  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ELEM_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [9*ELEM_W-1:0] A,
  output logic [9*ELEM_W-1:0] B,
  output logic                start,
  input  logic                arr_valid,
  output logic                done,
  output logic                busy,
  output logic                err_len,
  output logic                err_tmo
);

  localparam int            OPW      = 9 * ELEM_W;
  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [4:0]    LAST_IDX = 5'd17;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRE  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [OPW-1:0] r_bank_a [2];
  logic [OPW-1:0] r_bank_b [2];
  logic [1:0]     r_full;
  logic [1:0]     w_full_nxt;
  logic           r_wr_bank;
  logic           r_rd_bank;
  logic [4:0]     r_cnt;
  logic [TW-1:0]  r_tmo_cnt;
  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;

  logic w_xfer;
  logic w_last_ok;
  logic w_len_bad;
  logic w_issue;
  logic w_fire_ok;
  logic w_fire_tmo;
  logic w_release;

  // --------------------------------------------------------------------------
  // Load side
  // --------------------------------------------------------------------------
  assign in_ready  = ~r_full[r_wr_bank];
  assign w_xfer    = in_valid & in_ready;
  assign w_last_ok = w_xfer & in_last & (r_cnt == LAST_IDX);
  // Either in_last arrives early, or the 18th beat arrives without it.
  assign w_len_bad = w_xfer & (in_last ^ (r_cnt == LAST_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 5'd0;
      r_wr_bank <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_len <= w_len_bad;
      if (w_last_ok) begin
        r_cnt     <= 5'd0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_len_bad) begin
        // Partial bank is abandoned; its full flag was never set.
        r_cnt <= 5'd0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  // Bank storage holds pure data; validity lives in r_full, so no reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      for (int i = 0; i < 9; i++) begin
        if (r_cnt == 5'(i))
          r_bank_a[r_wr_bank][i*ELEM_W +: ELEM_W] <= in_data;
        if (r_cnt == 5'(i + 9))
          r_bank_b[r_wr_bank][i*ELEM_W +: ELEM_W] <= in_data;
      end
    end
  end

  // Fill and release touch different banks, so both bit updates can land
  // in the same cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_last_ok) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_full[r_rd_bank])                      w_state_nxt = S_FIRE;
      S_FIRE:  if (arr_valid || (r_tmo_cnt == TMO_LAST))   w_state_nxt = S_DRAIN;
      S_DRAIN: if (!arr_valid)                             w_state_nxt = S_IDLE;
      default:                                             w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue    = 1'b0;
    w_fire_ok  = 1'b0;
    w_fire_tmo = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      S_IDLE:  w_issue = r_full[r_rd_bank];
      S_FIRE: begin
        w_fire_ok  = arr_valid;
        w_fire_tmo = ~arr_valid & (r_tmo_cnt == TMO_LAST);
      end
      // The array clears valid only after it has seen start low.
      S_DRAIN: w_release = ~arr_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A         <= '0;
      B         <= '0;
      start     <= 1'b0;
      done      <= 1'b0;
      err_tmo   <= 1'b0;
      r_tmo_cnt <= '0;
      r_full    <= 2'b00;
      r_rd_bank <= 1'b0;
    end else begin
      done    <= w_fire_ok;
      err_tmo <= w_fire_tmo;
      r_full  <= w_full_nxt;
      if (w_issue) begin
        A         <= r_bank_a[r_rd_bank];
        B         <= r_bank_b[r_rd_bank];
        start     <= 1'b1;
        r_tmo_cnt <= '0;
      end else if (w_fire_ok || w_fire_tmo) begin
        start <= 1'b0;
      end else if (r_state == S_FIRE) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign busy = (|r_full) | (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sysarr_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysarr_operand_loader
// Purpose  : Self-checking bench for sysarr_operand_loader. A behavioural
//            array model answers start with arr_valid after a programmable
//            latency; expected operands come from 3x3 matrices packed
//            row-major by the bench.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysarr_operand_loader;

  localparam int ELEM_W  = 8;
  localparam int TIMEOUT = 32;
  localparam int OPW     = 9 * ELEM_W;

  typedef logic [7:0] mat_t [3][3];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ELEM_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [OPW-1:0]    A;
  logic [OPW-1:0]    B;
  logic              start;
  logic              arr_valid;
  logic              done;
  logic              busy;
  logic              err_len;
  logic              err_tmo;

  int n_cmp = 0;
  int n_bad = 0;

  sysarr_operand_loader #(.ELEM_W(ELEM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .start     (start),
    .arr_valid (arr_valid),
    .done      (done),
    .busy      (busy),
    .err_len   (err_len),
    .err_tmo   (err_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: after arr_lat cycles of start, raise valid; hold it until
  // start is seen low, then clear.
  int arr_lat   = 8;
  bit arr_never = 1'b0;
  int arr_cnt   = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_valid <= 1'b0;
      arr_cnt   <= 0;
    end else if (arr_valid) begin
      if (!start) arr_valid <= 1'b0;
    end else if (start && !arr_never) begin
      if (arr_cnt >= arr_lat - 1) begin
        arr_valid <= 1'b1;
        arr_cnt   <= 0;
      end else begin
        arr_cnt <= arr_cnt + 1;
      end
    end else begin
      arr_cnt <= 0;
    end
  end

  // Event recorder, sampled 1 time unit after each rising edge.
  logic [OPW-1:0] got_a[$];
  logic [OPW-1:0] got_b[$];
  int             got_cyc[$];
  int  n_done = 0, n_errlen = 0, n_errtmo = 0;
  int  cur_len = 0, last_len = 0, ab_unstable = 0, done_misaligned = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (start && !prev_start) begin
        got_a.push_back(A);
        got_b.push_back(B);
        got_cyc.push_back(cyc);
        cur_len = 0;
      end
      if (start) begin
        cur_len++;
        if (A !== got_a[$] || B !== got_b[$]) ab_unstable++;
      end
      if (!start && prev_start) last_len = cur_len;
      if (done) begin
        n_done++;
        if (!(prev_start && !start)) done_misaligned++;
      end
      if (err_len) n_errlen++;
      if (err_tmo) n_errtmo++;
    end
    prev_start = start;
  end

  // --------------------------------------------------------------------------
  // Reference helpers
  // --------------------------------------------------------------------------
  function automatic logic [OPW-1:0] pack(input mat_t m);
    logic [OPW-1:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[8*(3*r+c) +: 8] = m[r][c];
    return v;
  endfunction

  task automatic rand_mat(output mat_t m);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = 8'($urandom);
  endtask

  task automatic clear_log;
    got_a.delete();
    got_b.delete();
    got_cyc.delete();
  endtask

  // Called just after a falling edge; returns just after the next falling
  // edge following acceptance. acc = rising edges completed before acceptance.
  task automatic send_beat(input logic [7:0] d, input bit last, output int acc);
    int w;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
    end
    acc = cyc;
    @(negedge clk);
  endtask

  task automatic send_stream(input mat_t ma, input mat_t mb, input int nbeats,
                             input int last_at, output int acc);
    logic [7:0] e;
    for (int k = 0; k < nbeats; k++) begin
      e = (k < 9) ? ma[k/3][k%3] : mb[(k-9)/3][(k-9)%3];
      send_beat(e, (k == last_at), acc);
    end
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_starts(input int n, output bit ok);
    int w;
    w = 0;
    while (got_a.size() < n && w < 2000) begin
      @(negedge clk);
      w++;
    end
    ok = (got_a.size() >= n);
  endtask

  task automatic wait_done(input int n, output bit ok);
    int w;
    w = 0;
    while (n_done < n && w < 2000) begin
      @(negedge clk);
      w++;
    end
    ok = (n_done >= n);
  endtask

  task automatic settle;
    int w;
    w = 0;
    while (busy && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_cmp++; if (A !== '0 || B !== '0) begin n_bad++; $display("FAIL reset_ab: A=%h B=%h required 0", A, B); end
    n_cmp++; if (start !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_start_done: start=%b done=%b required 0", start, done); end
    n_cmp++; if (err_len !== 1'b0 || err_tmo !== 1'b0) begin n_bad++; $display("FAIL reset_err: err_len=%b err_tmo=%b required 0", err_len, err_tmo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: busy=%b required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_single;
    mat_t ma, mb;
    int acc, d0, s;
    bit ok;
    logic [OPW-1:0] cm;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 8'(3*r + c + 1);
        mb[r][c] = (r == c) ? 8'd1 : 8'd0;
      end
    clear_log();
    d0 = n_done;
    arr_lat = 8;
    arr_never = 1'b0;
    send_stream(ma, mb, 18, 17, acc);
    idle_inputs();
    wait_starts(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_start: starts=%0d required 1", got_a.size()); end
    if (ok) begin
      n_cmp++; if (got_cyc[0] - acc != 2) begin n_bad++; $display("FAIL single_latency: %0d cycles required 2", got_cyc[0] - acc); end
      n_cmp++; if (got_a[0] !== pack(ma)) begin n_bad++; $display("FAIL single_A: got %h required %h", got_a[0], pack(ma)); end
      n_cmp++; if (got_b[0] !== pack(mb)) begin n_bad++; $display("FAIL single_B: got %h required %h", got_b[0], pack(mb)); end
      cm = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          s = 0;
          for (int k = 0; k < 3; k++)
            s += int'(got_a[0][8*(3*r+k) +: 8]) * int'(got_b[0][8*(3*k+c) +: 8]);
          cm[8*(3*r+c) +: 8] = 8'(s);
        end
      n_cmp++; if (cm !== pack(ma)) begin n_bad++; $display("FAIL single_C_eq_A: C=%h required %h", cm, pack(ma)); end
    end
    wait_done(d0 + 1, ok);
    settle();
    n_cmp++; if (n_done != d0 + 1) begin n_bad++; $display("FAIL single_done_count: %0d pulses required 1", n_done - d0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: busy=%b required 0", busy); end
  endtask

  task automatic test_stream;
    mat_t ma[3], mb[3];
    int acc, d0;
    bit ok;
    for (int p = 0; p < 3; p++) begin
      rand_mat(ma[p]);
      rand_mat(mb[p]);
    end
    clear_log();
    d0 = n_done;
    arr_lat = 30;
    send_stream(ma[0], mb[0], 18, 17, acc);
    send_stream(ma[1], mb[1], 18, 17, acc);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stream_both_full: in_ready=%b required 0", in_ready); end
    send_stream(ma[2], mb[2], 18, 17, acc);
    idle_inputs();
    wait_starts(3, ok);
    wait_done(d0 + 3, ok);
    n_cmp++; if (got_a.size() != 3) begin n_bad++; $display("FAIL stream_start_count: %0d required 3", got_a.size()); end
    for (int p = 0; p < 3; p++) begin
      if (p < got_a.size()) begin
        n_cmp++; if (got_a[p] !== pack(ma[p]) || got_b[p] !== pack(mb[p])) begin
          n_bad++; $display("FAIL stream_pair%0d: A=%h B=%h required A=%h B=%h", p, got_a[p], got_b[p], pack(ma[p]), pack(mb[p]));
        end
      end
    end
    settle();
    n_cmp++; if (n_done != d0 + 3) begin n_bad++; $display("FAIL stream_done_count: %0d required 3", n_done - d0); end
  endtask

  task automatic test_len_err;
    mat_t ma, mb, ma2, mb2;
    int acc, e0, d0;
    bit ok;
    rand_mat(ma); rand_mat(mb); rand_mat(ma2); rand_mat(mb2);
    clear_log();
    arr_lat = 8;
    e0 = n_errlen;
    d0 = n_done;
    // in_last on beat index 5
    send_stream(ma, mb, 6, 5, acc);
    idle_inputs();
    n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL len_early_pulse: err_len=%b required 1", err_len); end
    @(negedge clk);
    n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL len_early_width: err_len=%b required 0", err_len); end
    repeat (6) @(negedge clk);
    n_cmp++; if (got_a.size() != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL len_early_discard: starts=%0d busy=%b required 0/0", got_a.size(), busy); end
    // 18th beat without in_last
    send_stream(ma, mb, 18, -1, acc);
    idle_inputs();
    n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL len_missing_pulse: err_len=%b required 1", err_len); end
    repeat (6) @(negedge clk);
    n_cmp++; if (n_errlen != e0 + 2) begin n_bad++; $display("FAIL len_err_count: %0d required 2", n_errlen - e0); end
    n_cmp++; if (got_a.size() != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL len_missing_discard: starts=%0d busy=%b required 0/0", got_a.size(), busy); end
    send_stream(ma2, mb2, 18, 17, acc);
    idle_inputs();
    wait_starts(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL len_recover_start: starts=%0d required 1", got_a.size()); end
    if (ok) begin
      n_cmp++; if (got_a[0] !== pack(ma2) || got_b[0] !== pack(mb2)) begin
        n_bad++; $display("FAIL len_recover_data: A=%h B=%h required A=%h B=%h", got_a[0], got_b[0], pack(ma2), pack(mb2));
      end
    end
    wait_done(d0 + 1, ok);
    settle();
  endtask

  task automatic test_timeout;
    mat_t ma[2], mb[2];
    int acc, t0, d0, w;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      rand_mat(ma[p]);
      rand_mat(mb[p]);
    end
    clear_log();
    t0 = n_errtmo;
    d0 = n_done;
    arr_never = 1'b1;
    send_stream(ma[0], mb[0], 18, 17, acc);
    send_stream(ma[1], mb[1], 18, 17, acc);
    idle_inputs();
    w = 0;
    while (n_errtmo == t0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    arr_never = 1'b0;
    arr_lat = 8;
    n_cmp++; if (n_errtmo != t0 + 1) begin n_bad++; $display("FAIL tmo_pulse: %0d pulses required 1", n_errtmo - t0); end
    n_cmp++; if (last_len != TIMEOUT) begin n_bad++; $display("FAIL tmo_start_len: %0d cycles required %0d", last_len, TIMEOUT); end
    n_cmp++; if (n_done != d0) begin n_bad++; $display("FAIL tmo_no_done: %0d pulses required 0", n_done - d0); end
    wait_starts(2, ok);
    wait_done(d0 + 1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_next_done: %0d pulses required 1", n_done - d0); end
    if (got_a.size() >= 2) begin
      n_cmp++; if (got_a[0] !== pack(ma[0]) || got_a[1] !== pack(ma[1]) || got_b[1] !== pack(mb[1])) begin
        n_bad++; $display("FAIL tmo_next_data: A1=%h B1=%h required A1=%h B1=%h", got_a[1], got_b[1], pack(ma[1]), pack(mb[1]));
      end
    end
    settle();
    n_cmp++; if (busy !== 1'b0 || n_errtmo != t0 + 1) begin n_bad++; $display("FAIL tmo_freed: busy=%b tmo=%0d required 0/1", busy, n_errtmo - t0); end
  endtask

  task automatic test_reset_mid;
    mat_t ma, mb;
    int acc, d0;
    bit ok;
    rand_mat(ma); rand_mat(mb);
    clear_log();
    arr_never = 1'b1;
    send_stream(ma, mb, 18, 17, acc);
    idle_inputs();
    wait_starts(1, ok);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_start_busy: start=%b busy=%b required 0/0", start, busy); end
    n_cmp++; if (A !== '0 || B !== '0) begin n_bad++; $display("FAIL rstmid_ab: A=%h B=%h required 0", A, B); end
    @(negedge clk);
    rst_n = 1'b1;
    arr_never = 1'b0;
    arr_lat = 8;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_release: in_ready=%b busy=%b required 1/0", in_ready, busy); end
    clear_log();
    d0 = n_done;
    rand_mat(ma); rand_mat(mb);
    send_stream(ma, mb, 18, 17, acc);
    idle_inputs();
    wait_starts(1, ok);
    wait_done(d0 + 1, ok);
    n_cmp++; if (got_a.size() != 1 || !ok) begin n_bad++; $display("FAIL rstmid_new_pair: starts=%0d done=%0d required 1/1", got_a.size(), n_done - d0); end
    if (got_a.size() >= 1) begin
      n_cmp++; if (got_a[0] !== pack(ma) || got_b[0] !== pack(mb)) begin
        n_bad++; $display("FAIL rstmid_data: A=%h B=%h required A=%h B=%h", got_a[0], got_b[0], pack(ma), pack(mb));
      end
    end
    settle();
  endtask

  task automatic test_overlap;
    mat_t ma[3], mb[3];
    int acc, acc2, d0, w;
    bit ok;
    for (int p = 0; p < 3; p++) begin
      rand_mat(ma[p]);
      rand_mat(mb[p]);
    end
    clear_log();
    d0 = n_done;
    arr_lat = 25;
    send_stream(ma[0], mb[0], 18, 17, acc);
    send_stream(ma[1], mb[1], 17, -1, acc);
    idle_inputs();
    w = 0;
    while (n_done == d0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    // done seen: array clears valid next edge, DRAIN exits the edge after.
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL overlap_ready_pre: in_ready=%b required 1", in_ready); end
    in_data  = mb[1][2][2];
    in_last  = 1'b1;
    in_valid = 1'b1;
    acc2 = cyc;
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL overlap_flags: in_ready=%b busy=%b required 1/1", in_ready, busy); end
    send_stream(ma[2], mb[2], 18, 17, acc);
    idle_inputs();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL overlap_both_full: in_ready=%b required 0", in_ready); end
    wait_starts(3, ok);
    wait_done(d0 + 3, ok);
    n_cmp++; if (got_a.size() != 3 || !ok) begin n_bad++; $display("FAIL overlap_counts: starts=%0d done=%0d required 3/3", got_a.size(), n_done - d0); end
    if (got_a.size() >= 2) begin
      n_cmp++; if (got_cyc[1] - acc2 != 2) begin n_bad++; $display("FAIL overlap_issue_latency: %0d cycles required 2", got_cyc[1] - acc2); end
    end
    for (int p = 0; p < 3; p++) begin
      if (p < got_a.size()) begin
        n_cmp++; if (got_a[p] !== pack(ma[p]) || got_b[p] !== pack(mb[p])) begin
          n_bad++; $display("FAIL overlap_pair%0d: A=%h B=%h required A=%h B=%h", p, got_a[p], got_b[p], pack(ma[p]), pack(mb[p]));
        end
      end
    end
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL overlap_busy_after: busy=%b required 0", busy); end
  endtask

  task automatic test_handshake_integrity;
    n_cmp++; if (ab_unstable != 0) begin n_bad++; $display("FAIL ab_hold_during_start: %0d changes required 0", ab_unstable); end
    n_cmp++; if (done_misaligned != 0) begin n_bad++; $display("FAIL done_with_start_fall: %0d misaligned required 0", done_misaligned); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_len_err();
    test_timeout();
    test_reset_mid();
    test_overlap();
    test_handshake_integrity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
